// File: rtl/text_frame_renderer_if.sv
// rtl/text_frame_renderer_if.sv - pixel beat stream between the text renderer and the framebuffer writer
interface text_frame_renderer_if #(
  parameter int DATA_W = 32,
  parameter int Y_W    = 9,
  parameter int COL_W  = 7
);
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic [Y_W-1:0]    pix_y;
  logic [COL_W-1:0]  pix_col;

  modport master (output pix_valid, pix_data, pix_y, pix_col, input pix_ready);
  modport slave  (input pix_valid, pix_data, pix_y, pix_col, output pix_ready);
endinterface

// File: rtl/text_frame_renderer.sv
// rtl/text_frame_renderer.sv - raster text-grid renderer: text RAM + font ROM -> glyph-row pixel beats
// Optional macro CURSOR_UNDERLINE_EN: cursor drawn as an underline on the last two glyph rows instead of a block.
module text_frame_renderer #(
  parameter int CONSOLE_LINES        = 24,
  parameter int CONSOLE_COLUMNS      = 80,
  parameter int COLOR_NUMBERS_BITS   = 4,
  parameter int HEIGHT_PER_CHARACTER = 20,
  parameter int WIDTH_PER_CHARACTER  = 8,
  parameter int BLINK_FRAMES         = 30,
  localparam int CB     = COLOR_NUMBERS_BITS,
  localparam int H      = HEIGHT_PER_CHARACTER,
  localparam int W      = WIDTH_PER_CHARACTER,
  localparam int TA_W   = $clog2(CONSOLE_LINES * CONSOLE_COLUMNS),
  localparam int GROW_W = $clog2(H),
  localparam int FA_W   = 8 + GROW_W,
  localparam int Y_W    = $clog2(CONSOLE_LINES * H),
  localparam int COL_W  = $clog2(CONSOLE_COLUMNS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [TA_W-1:0]      text_addr,
  input  logic [8+2*CB-1:0]    text_data,
  output logic [FA_W-1:0]      font_addr,
  input  logic [W-1:0]         font_data,
  input  logic [7:0]           cursor_line,
  input  logic [7:0]           cursor_col,
  input  logic [1:0]           cursor_mode,
  text_frame_renderer_if.master pix
);

  localparam int LINE_W = (CONSOLE_LINES > 1) ? $clog2(CONSOLE_LINES) : 1;
  localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TA_W-1:0] LINE_STEP = TA_W'(CONSOLE_COLUMNS);

  typedef enum logic [2:0] {
    IDLE, CELL_REQ, CELL_WAIT, GLYPH_REQ, GLYPH_WAIT, EMIT, FIN
  } state_t;

  state_t state, state_nx;

  logic [COL_W-1:0]  col;
  logic [GROW_W-1:0] grow;
  logic [LINE_W-1:0] line;
  logic [Y_W-1:0]    y;
  logic [TA_W-1:0]   line_base;

  logic [7:0]        cur_line, cur_col;
  logic [1:0]        cur_mode;
  logic [7:0]        chr;
  logic [CB-1:0]     fg, bg;
  logic [W*CB-1:0]   pix_buf, pix_next;
  logic [FC_W-1:0]   frame_cnt;
  logic              blink_phase;
  logic              pix_valid_c;

  logic last_col, last_grow, last_beat;
  logic cursor_in_range, cursor_here, cursor_shown, overlay;
  logic [CB-1:0] fg_eff, bg_eff;
  logic force_fg;

  assign last_col  = 32'(col) == CONSOLE_COLUMNS - 1;
  assign last_grow = 32'(grow) == H - 1;
  assign last_beat = last_col && (32'(y) == CONSOLE_LINES * H - 1);

  // line_base tracks line*COLUMNS so no multiplier sits on the address path
  assign text_addr = line_base + TA_W'(col);
  assign font_addr = {chr, grow};

  assign pix.pix_valid = pix_valid_c;
  assign pix.pix_data  = pix_buf;
  assign pix.pix_y     = y;
  assign pix.pix_col   = col;

  assign cursor_in_range = (32'(cur_line) < CONSOLE_LINES) && (32'(cur_col) < CONSOLE_COLUMNS);
  assign cursor_here     = (32'(line) == 32'(cur_line)) && (32'(col) == 32'(cur_col));
  assign cursor_shown    = (cur_mode == 2'd2) || ((cur_mode == 2'd0) && blink_phase);
  assign overlay         = cursor_in_range && cursor_here && cursor_shown;

  always_comb begin
    fg_eff   = fg;
    bg_eff   = bg;
    force_fg = 1'b0;
`ifdef CURSOR_UNDERLINE_EN
    force_fg = overlay && (32'(grow) >= H - 2);
`else
    if (overlay) begin
      fg_eff = bg;
      bg_eff = fg;
    end
`endif
    pix_next = '0;
    for (int i = 0; i < W; i++) begin
      pix_next[i*CB +: CB] = (force_fg || font_data[W-1-i]) ? fg_eff : bg_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    busy        = 1'b0;
    done        = 1'b0;
    pix_valid_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = CELL_REQ;
      end
      CELL_REQ: begin
        busy     = 1'b1;
        state_nx = CELL_WAIT;
      end
      CELL_WAIT: begin
        busy     = 1'b1;
        state_nx = GLYPH_REQ;
      end
      GLYPH_REQ: begin
        busy     = 1'b1;
        state_nx = GLYPH_WAIT;
      end
      GLYPH_WAIT: begin
        busy     = 1'b1;
        state_nx = EMIT;
      end
      EMIT: begin
        busy        = 1'b1;
        pix_valid_c = 1'b1;
        if (pix.pix_ready) state_nx = last_beat ? FIN : CELL_REQ;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      grow        <= '0;
      line        <= '0;
      y           <= '0;
      line_base   <= '0;
      cur_line    <= '0;
      cur_col     <= '0;
      cur_mode    <= '0;
      chr         <= '0;
      fg          <= '0;
      bg          <= '0;
      pix_buf     <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_line  <= cursor_line;
            cur_col   <= cursor_col;
            cur_mode  <= cursor_mode;
            col       <= '0;
            grow      <= '0;
            line      <= '0;
            y         <= '0;
            line_base <= '0;
          end
        end
        CELL_WAIT: begin
          chr <= text_data[7:0];
          fg  <= text_data[8 +: CB];
          bg  <= text_data[8+CB +: CB];
        end
        GLYPH_WAIT: pix_buf <= pix_next;
        EMIT: begin
          // counters freeze on the final beat so they never step into unused codes
          if (pix.pix_ready && !last_beat) begin
            if (last_col) begin
              col <= '0;
              y   <= y + 1'b1;
              if (last_grow) begin
                grow      <= '0;
                line      <= line + 1'b1;
                line_base <= line_base + LINE_STEP;
              end else begin
                grow <= grow + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        FIN: begin
          if (32'(frame_cnt) == BLINK_FRAMES - 1) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/text_frame_renderer.md
Name: text_frame_renderer

Overview:
- Parametrised successor to the console text renderer. Walks the character grid in raster order and reads each cell's {background, foreground, char} word from text RAM.
- Fetches the matching glyph row from font ROM and applies fg/bg palette indices and cursor overlay. Streams one glyph-row beat (WIDTH_PER_CHARACTER pixels) per handshake to the framebuffer writer.
- Sits between the terminal state RAM/font ROM and the SRAM framebuffer writer. Rendering is one frame per start pulse.

Parameters:
- CONSOLE_LINES, 24, character rows.
- CONSOLE_COLUMNS, 80, character columns.
- COLOR_NUMBERS_BITS, 4, palette index width (CB).
- HEIGHT_PER_CHARACTER, 20, glyph rows per cell (H).
- WIDTH_PER_CHARACTER, 8, pixels per glyph row (W).
- BLINK_FRAMES, 30, frames per cursor blink half-period (>=1).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin a frame (ignored while busy).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last beat handshake.
- text_addr  out  $clog2(LINES*COLUMNS)  cell index = line*COLUMNS+col.
- text_data  in  8+2*CB  {bg, fg, char}; valid the cycle after text_addr.
- font_addr  out  8+$clog2(H)  {char, glyph_row}.
- font_data  in  W  glyph row, MSB = leftmost pixel; valid the cycle after font_addr.
- cursor_line  in  8  cursor row.
- cursor_col  in  8  cursor column.
- cursor_mode  in  2  0 blinking, 1 invisible, 2 persistent, 3 = invisible.
- pix_valid  out  1  beat valid.
- pix_ready  in  1  sink accepts beat.
- pix_data  out  W*CB  pixel i (0 = leftmost) at [i*CB +: CB].
- pix_y  out  $clog2(LINES*H)  scanline.
- pix_col  out  $clog2(COLUMNS)  cell column.

Behaviour:
- Reset: all outputs 0, state IDLE, frame counter 0, blink_phase 1 (visible). Reset mid-frame aborts immediately with no done pulse.
- FSM: IDLE -> CELL_REQ -> CELL_WAIT -> GLYPH_REQ -> GLYPH_WAIT -> EMIT -> (CELL_REQ | FIN) -> IDLE.
  - IDLE: on start, latch cursor_line/col/mode, clear y and col, set busy.
  - CELL_REQ: drive text_addr for (y/H, col).
  - CELL_WAIT: capture text_data.
  - GLYPH_REQ: drive font_addr {char, y%H}.
  - GLYPH_WAIT: capture font_data.
  - EMIT: pix_valid=1. pix_data/pix_y/pix_col are held stable until pix_ready. On handshake: col++; at col=COLUMNS-1, col=0 and y++. After the beat at y=LINES*H-1, col=COLUMNS-1, go to FIN.
  - FIN: done=1 for one cycle, busy=0, update blink counter, return to IDLE.
- Minimum 5 cycles per beat; LINES*H*COLUMNS beats per frame.
- Pixel colour: font bit set -> fg, else bg.
- Cursor overlay applies when all of the following hold:
  - the latched cursor is in range (line<LINES, col<COLUMNS);
  - the current cell matches the cursor;
  - the mode is persistent, or blinking with blink_phase=1.
- Cursor overlay effect: fg and bg are swapped for all H rows (block cursor). Out-of-range cursor -> no overlay.
- Blink: frame counter increments at FIN. On reaching BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- Row/column counters use the exact compare values above; no wrap into unused address codes.
- start while busy or in FIN: ignored. start in the same cycle as rst: rst wins.

Optional Feature:
- CURSOR_UNDERLINE_EN defined: the cursor overlay affects only glyph rows H-2 and H-1 of the cursor cell. Every pixel in those rows is forced to fg (no swap). Other rows render normally.
- CURSOR_UNDERLINE_EN undefined: block cursor (fg/bg swap on all rows) as above.

Test Plan:
- Reset values: assert rst 3 cycles -> busy=0, done=0, pix_valid=0, text_addr=0, font_addr=0.
- Single frame, LINES=2, COLUMNS=3, H=4, W=8, BLINK_FRAMES=2, pix_ready=1, every cell {bg=1, fg=F, char=41h}, font row = 81h, cursor_mode=1:
  - -> 24 beats, each pix_data=F111111Fh (pixel0=F, pixels1-6=1, pixel7=F);
  - -> pix_y/pix_col in raster order;
  - -> single done pulse; frame takes >=120 cycles.
- Backpressure: hold pix_ready=0 for 3 cycles on beat 5 -> pix_valid, pix_data, pix_y and pix_col stay constant; no text/font address advance.
- Cursor persistent at (1,2) -> only beats with pix_y in 4..7 and pix_col=2 show 1FFFFFF1h. With CURSOR_UNDERLINE_EN: only pix_y 6,7 at col 2 show FFFFFFFFh.
- Blink mode over 4 frames -> cursor visible in frames 0,1; hidden in 2,3. Cursor (5,0) out of range -> never drawn.
- start pulse mid-frame -> ignored (beat count unchanged). rst at beat 10 -> outputs 0, no done; the next start renders a full frame.
